// File: rtl/gpio_config_shift_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_config_shift_receiver_if
// Description : Serial configuration chain and live config bundle for one pad.
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_config_shift_receiver_if #(
  parameter int WIDTH = 10
);
  logic             serial_data_in;
  logic             serial_enable;
  logic             serial_load;
  logic             load_defaults;
  logic             serial_data_out;
  logic [WIDTH-1:0] gpio_config;
  logic             cfg_valid;
  logic             load_done;
  logic             load_error;

  // Housekeeping side drives the strobes and observes the live configuration.
  modport master (
    output serial_data_in, serial_enable, serial_load, load_defaults,
    input  serial_data_out, gpio_config, cfg_valid, load_done, load_error
  );

  modport slave (
    input  serial_data_in, serial_enable, serial_load, load_defaults,
    output serial_data_out, gpio_config, cfg_valid, load_done, load_error
  );
endinterface
`default_nettype wire

// File: rtl/gpio_config_shift_receiver.sv
`default_nettype none
// ============================================================================
// Module      : gpio_config_shift_receiver
// Description : Per-pad GPIO config register; loads defaults, then commits
//               full frames received over the serial configuration chain.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_config_shift_receiver #(
  parameter int WIDTH = 10
) (
  input  wire logic                        serial_clock,
  input  wire logic                        resetn,
  input  wire logic [WIDTH-1:0]            gpio_defaults,
  gpio_config_shift_receiver_if.slave      bus
);

  localparam int                 c_cnt_w = $clog2(WIDTH + 1);
  localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(WIDTH);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2,
    S_FULL  = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift_reg;
  logic [c_cnt_w-1:0] r_bit_cnt;
  logic [WIDTH-1:0]   r_gpio_config;
  logic               r_cfg_valid;
  logic               r_load_done;
  logic               r_load_error;
  logic [c_cnt_w-1:0] w_cnt_next;

  // The count saturates so a pass-through chain never wraps back to "empty".
  assign w_cnt_next = (r_bit_cnt == c_full) ? c_full : r_bit_cnt + 1'b1;

  always_ff @(posedge serial_clock or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_INIT;
      r_shift_reg   <= '0;
      r_bit_cnt     <= '0;
      r_gpio_config <= '0;
      r_cfg_valid   <= 1'b0;
      r_load_done   <= 1'b0;
      r_load_error  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      if (r_state == S_INIT) begin
        r_gpio_config <= gpio_defaults;
        r_cfg_valid   <= 1'b1;
        r_state       <= S_IDLE;
      end else if (bus.load_defaults) begin
        r_gpio_config <= gpio_defaults;
        r_shift_reg   <= '0;
        r_bit_cnt     <= '0;
        r_load_error  <= 1'b0;
        r_state       <= S_IDLE;
      end else if (bus.serial_load) begin
        // A same-cycle shift is dropped so the committed word is the framed one.
        if (r_state == S_FULL) begin
          r_gpio_config <= r_shift_reg;
          r_load_done   <= 1'b1;
          r_load_error  <= 1'b0;
        end else begin
          r_load_error  <= 1'b1;
        end
        r_bit_cnt <= '0;
        r_state   <= S_IDLE;
      end else if (bus.serial_enable) begin
        r_shift_reg <= {r_shift_reg[WIDTH-2:0], bus.serial_data_in};
        r_bit_cnt   <= w_cnt_next;
        if (r_state != S_FULL) begin
          r_state <= (w_cnt_next == c_full) ? S_FULL : S_SHIFT;
        end
      end
    end
  end

  assign bus.serial_data_out = r_shift_reg[WIDTH-1];
  assign bus.gpio_config     = r_gpio_config;
  assign bus.cfg_valid       = r_cfg_valid;
  assign bus.load_done       = r_load_done;
  assign bus.load_error      = r_load_error;

endmodule
`default_nettype wire

// File: tb/tb_gpio_config_shift_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_config_shift_receiver
// Description : Directed self-checking bench for gpio_config_shift_receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_config_shift_receiver;

  localparam int WIDTH = 10;

  logic             serial_clock;
  logic             resetn;
  logic [WIDTH-1:0] gpio_defaults;
  int               n_assert;
  int               n_fail;

  gpio_config_shift_receiver_if #(.WIDTH(WIDTH)) bus ();

  gpio_config_shift_receiver #(.WIDTH(WIDTH)) dut (
    .serial_clock  (serial_clock),
    .resetn        (resetn),
    .gpio_defaults (gpio_defaults),
    .bus           (bus)
  );

  initial serial_clock = 1'b0;
  always #5 serial_clock = ~serial_clock;

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock with the given strobes; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input logic en, input logic din, input logic ld, input logic dflt);
    bus.serial_enable  = en;
    bus.serial_data_in = din;
    bus.serial_load    = ld;
    bus.load_defaults  = dflt;
    @(posedge serial_clock);
    #1;
    bus.serial_enable  = 1'b0;
    bus.serial_data_in = 1'b0;
    bus.serial_load    = 1'b0;
    bus.load_defaults  = 1'b0;
  endtask

  task automatic shift_bits(input logic [WIDTH-1:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] pat;
    n_assert = 0;
    n_fail   = 0;
    bus.serial_enable  = 1'b0;
    bus.serial_data_in = 1'b0;
    bus.serial_load    = 1'b0;
    bus.load_defaults  = 1'b0;
    gpio_defaults      = 10'h009;
    resetn             = 1'b0;

    // Reset held for three cycles
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_config",    16'(bus.gpio_config), 16'h000);
    chk("rst_valid",     16'(bus.cfg_valid),   16'h0);
    chk("rst_done",      16'(bus.load_done),   16'h0);
    chk("rst_error",     16'(bus.load_error),  16'h0);
    chk("rst_sdo",       16'(bus.serial_data_out), 16'h0);
    resetn = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("init_config",   16'(bus.gpio_config), 16'h009);
    chk("init_valid",    16'(bus.cfg_valid),   16'h1);
    chk("init_sdo",      16'(bus.serial_data_out), 16'h0);

    // Full frame commit
    shift_bits(10'h2A5, 10);
    chk("frame_hold",    16'(bus.gpio_config), 16'h009);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("commit_config", 16'(bus.gpio_config), 16'h2A5);
    chk("commit_done",   16'(bus.load_done),   16'h1);
    chk("commit_error",  16'(bus.load_error),  16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_pulse",    16'(bus.load_done),   16'h0);

    // Incomplete frame
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("dflt_config",   16'(bus.gpio_config), 16'h009);
    chk("dflt_done",     16'(bus.load_done),   16'h0);
    shift_bits(10'h07F, 7);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("short_config",  16'(bus.gpio_config), 16'h009);
    chk("short_error",   16'(bus.load_error),  16'h1);
    chk("short_done",    16'(bus.load_done),   16'h0);

    // 20-bit pass-through
    pat = 10'h3FF;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, (i <= 10) ? pat[WIDTH - i] : 1'(10'h155 >> (20 - i)), 1'b0, 1'b0);
      if (i >= 10 && i <= 19) chk($sformatf("sdo_%0d", i), 16'(bus.serial_data_out), 16'h1);
    end
    chk("sdo_20",        16'(bus.serial_data_out), 16'h0);
    chk("sticky_error",  16'(bus.load_error),  16'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pass_config",   16'(bus.gpio_config), 16'h155);
    chk("pass_done",     16'(bus.load_done),   16'h1);
    chk("pass_error",    16'(bus.load_error),  16'h0);

    // load_defaults clears error and bit count
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_load_err", 16'(bus.load_error),  16'h1);
    shift_bits(10'h01F, 5);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_config",    16'(bus.gpio_config), 16'h009);
    chk("clr_error",     16'(bus.load_error),  16'h0);
    chk("clr_sdo",       16'(bus.serial_data_out), 16'h0);
    shift_bits(10'h1FF, 9);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("cnt_cleared",   16'(bus.load_error),  16'h1);
    chk("cnt_config",    16'(bus.gpio_config), 16'h009);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    shift_bits(10'h0F0, 10);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("f0_config",     16'(bus.gpio_config), 16'h0F0);
    chk("f0_done",       16'(bus.load_done),   16'h1);

    // Load and enable together: commit wins, shift is dropped
    gpio_defaults = 10'h3FF;
    shift_bits(10'h3C3, 10);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("both_config",   16'(bus.gpio_config), 16'h3C3);
    chk("both_done",     16'(bus.load_done),   16'h1);
    chk("dflt_unsampled", 16'(bus.gpio_config), 16'h3C3);
    gpio_defaults = 10'h009;
    shift_bits(10'h000, 3);
    chk("drop_sdo",      16'(bus.serial_data_out), 16'h1);
    shift_bits(10'h000, 1);
    chk("drop_sdo4",     16'(bus.serial_data_out), 16'h0);

    // Asynchronous reset mid-frame
    #2;
    resetn = 1'b0;
    #1;
    chk("async_config",  16'(bus.gpio_config), 16'h000);
    chk("async_valid",   16'(bus.cfg_valid),   16'h0);
    chk("async_done",    16'(bus.load_done),   16'h0);
    chk("async_sdo",     16'(bus.serial_data_out), 16'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("reload_config", 16'(bus.gpio_config), 16'h009);
    chk("reload_valid",  16'(bus.cfg_valid),   16'h1);
    chk("reload_error",  16'(bus.load_error),  16'h0);
    chk("reload_done",   16'(bus.load_done),   16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
